// File: rtl/neuron_mac_sequencer.sv
// Single-neuron dot-product sequencer: streams weight/activation pairs from two
// 1-cycle-latency memories, accumulates signed fixed-point products, then biases, saturates and ReLUs.
module neuron_mac_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WEIGHTS = 10,
    parameter int FRAC_BITS   = 16,
    parameter int RELU_EN     = 1,
    localparam int AW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic [AW-1:0]         rom_addr,
    output logic [AW-1:0]         act_addr,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + $clog2(NUM_WEIGHTS) + 1;
    localparam int TW    = ACC_W + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WEIGHTS - 1);
    localparam logic signed [TW-1:0] SAT_MAX = {{(TW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [TW-1:0] SAT_MIN = {{(TW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   next_state_s;
    logic [AW-1:0]            idx_r;
    logic                     data_vld_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [DATA_WIDTH-1:0]    result_r;
    logic                     valid_r;
    logic                     busy_r;
    logic                     acc_clr_s;
    logic                     idx_inc_s;
    logic                     load_s;
    logic                     accept_s;
    logic                     handshake_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic signed [TW-1:0]     tmp_s;

    function automatic logic [DATA_WIDTH-1:0] sat_relu(input logic signed [TW-1:0] v);
        logic [DATA_WIDTH-1:0] s;
        if (v > SAT_MAX) begin
            s = SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            s = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            s = v[DATA_WIDTH-1:0];
        end
        if ((RELU_EN != 0) && s[DATA_WIDTH-1]) begin
            s = {DATA_WIDTH{1'b0}};
        end
        return s;
    endfunction

    assign prod_s    = $signed(weight_in) * $signed(act_in);
    assign shifted_s = acc_r >>> FRAC_BITS;
    assign tmp_s     = {shifted_s[ACC_W-1], shifted_s} + {{(TW-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = FETCH;
                else       next_state_s = IDLE;
            end
            FETCH: begin
                if (idx_r == LAST_IDX) next_state_s = DRAIN;
                else                   next_state_s = FETCH;
            end
            DRAIN:   next_state_s = BIAS;
            BIAS:    next_state_s = OUT;
            OUT: begin
                if (result_ready) next_state_s = IDLE;
                else              next_state_s = OUT;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath control strobes decoded from the current state
    always_comb begin
        acc_clr_s   = 1'b0;
        idx_inc_s   = 1'b0;
        load_s      = 1'b0;
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                acc_clr_s = 1'b1;
                accept_s  = start;
            end
            FETCH: begin
                if (idx_r != LAST_IDX) idx_inc_s = 1'b1;
                else                   idx_inc_s = 1'b0;
            end
            DRAIN:   acc_clr_s = 1'b0;
            BIAS:    load_s = 1'b1;
            OUT:     handshake_s = result_ready && valid_r;
            default: acc_clr_s = 1'b1;
        endcase
    end

    // Address counter; data for an address arrives one cycle later, hence data_vld_r
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r      <= {AW{1'b0}};
            data_vld_r <= 1'b0;
        end else begin
            data_vld_r <= (state_r == FETCH);
            if (state_r == IDLE) begin
                idx_r <= {AW{1'b0}};
            end else if (idx_inc_s) begin
                idx_r <= idx_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Full-precision accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (acc_clr_s) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (data_vld_r) begin
            acc_r <= acc_r + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
        end else begin
            acc_r <= acc_r;
        end
    end

    // Result register and output handshake flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= {DATA_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (load_s) result_r <= sat_relu(tmp_s);
            else        result_r <= result_r;
            if (load_s)           valid_r <= 1'b1;
            else if (handshake_s) valid_r <= 1'b0;
            else                  valid_r <= valid_r;
            if (accept_s)         busy_r <= 1'b1;
            else if (handshake_s) busy_r <= 1'b0;
            else                  busy_r <= busy_r;
        end
    end

    assign rom_addr     = idx_r;
    assign act_addr     = idx_r;
    assign result       = result_r;
    assign result_valid = valid_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench: two NUM_WEIGHTS=4 instances (ReLU on/off) and a NUM_WEIGHTS=1 instance share control inputs.
module tb_neuron_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        result_ready = 1'b0;
    logic [31:0] bias = 32'h0;
    logic [31:0] bias2 = 32'h0;
    logic [31:0] w2 = 32'h0002_0000;
    logic [31:0] a2 = 32'h0003_0000;
    logic [31:0] wmem [4];
    logic [31:0] amem [4];
    logic [31:0] w0, a0, w1, a1;
    logic [1:0]  rom0, act0, rom1, act1;
    logic [0:0]  rom2, act2;
    logic [31:0] res0, res1, res2;
    logic        valid0, valid1, valid2, busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0][31:0] w;
        logic [3:0][31:0] a;
        logic [31:0]      b;
        logic [31:0]      exp_relu;
        logic [31:0]      exp_lin;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    neuron_mac_sequencer #(.DATA_WIDTH(32), .NUM_WEIGHTS(4), .FRAC_BITS(16), .RELU_EN(1)) u0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .rom_addr(rom0), .act_addr(act0),
        .weight_in(w0), .act_in(a0), .bias(bias), .result(res0), .result_valid(valid0),
        .result_ready(result_ready));

    neuron_mac_sequencer #(.DATA_WIDTH(32), .NUM_WEIGHTS(4), .FRAC_BITS(16), .RELU_EN(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .rom_addr(rom1), .act_addr(act1),
        .weight_in(w1), .act_in(a1), .bias(bias), .result(res1), .result_valid(valid1),
        .result_ready(result_ready));

    neuron_mac_sequencer #(.DATA_WIDTH(32), .NUM_WEIGHTS(1), .FRAC_BITS(16), .RELU_EN(1)) u2 (
        .clk(clk), .rst(rst), .start(start), .busy(busy2), .rom_addr(rom2), .act_addr(act2),
        .weight_in(w2), .act_in(a2), .bias(bias2), .result(res2), .result_valid(valid2),
        .result_ready(result_ready));

    // Weight ROM / activation buffer models with 1-cycle read latency
    always_ff @(posedge clk) begin
        w0 <= wmem[rom0];
        a0 <= amem[act0];
        w1 <= wmem[rom1];
        a1 <= amem[act1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_vec(input int i);
        for (int k = 0; k < 4; k++) begin
            wmem[k] = vecs[i].w[k];
            amem[k] = vecs[i].a[k];
        end
        bias = vecs[i].b;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called in cycle T+1; returns the cycle (relative to T) where valid first appears
    task automatic wait_valid(input bit pulse_mid, output int lat, output int lat2);
        int cyc;
        logic [31:0] exp_addr;
        lat = 0;
        lat2 = 0;
        cyc = 1;
        check("busy_after_start", {31'b0, busy0}, 32'd1);
        while (lat == 0 && cyc <= 30) begin
            if (valid2 && lat2 == 0) lat2 = cyc;
            if (valid0) begin
                lat = cyc;
            end else begin
                if (cyc <= 6) begin
                    exp_addr = (cyc <= 4) ? 32'(cyc - 1) : 32'd3;
                    check("rom_addr", {30'b0, rom0}, exp_addr);
                    check("act_addr", {30'b0, act0}, exp_addr);
                end
                start = pulse_mid && (cyc == 3);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (lat == 0) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("valid_after_hs", {31'b0, valid0}, 32'd0);
        check("busy_after_hs", {31'b0, busy0}, 32'd0);
        check("valid1_after_hs", {31'b0, valid1}, 32'd0);
    endtask

    task automatic run_vec(input int i, input logic [31:0] exp_r, input logic [31:0] exp_l);
        int lat, lat2;
        load_vec(i);
        pulse_start();
        wait_valid(1'b0, lat, lat2);
        check("latency", 32'(lat), 32'd7);
        check("latency_nw1", 32'(lat2), 32'd4);
        check("result_relu", res0, exp_r);
        check("result_lin", res1, exp_l);
        check("valid_lin", {31'b0, valid1}, 32'd1);
        check("result_nw1", res2, 32'h0006_0000);
        handshake();
    endtask

    initial begin
        int lat, lat2;
        logic [31:0] held;

        vecs[0] = '{w: {4{32'h0001_0000}},
                    a: {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
                    b: 32'h0000_8000, exp_relu: 32'h000A_8000, exp_lin: 32'h000A_8000};
        vecs[1] = '{w: {4{32'h0001_0000}}, a: {4{32'hFFFF_0000}},
                    b: 32'h0, exp_relu: 32'h0, exp_lin: 32'hFFFC_0000};
        vecs[2] = '{w: {4{32'h7FFF_FFFF}}, a: {4{32'h7FFF_FFFF}},
                    b: 32'h7FFF_FFFF, exp_relu: 32'h7FFF_FFFF, exp_lin: 32'h7FFF_FFFF};
        vecs[3] = '{w: {4{32'h7FFF_FFFF}}, a: {4{32'h8000_0001}},
                    b: 32'h8000_0001, exp_relu: 32'h0, exp_lin: 32'h8000_0000};
        // -1 raw product shifted right must floor to -1 LSB, not 0
        vecs[4] = '{w: {32'h0, 32'h0, 32'h0, 32'h0000_0001},
                    a: {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF},
                    b: 32'h0, exp_relu: 32'h0, exp_lin: 32'hFFFF_FFFF};
        // 1.5*2 + 2*(-1.5) + (-1)*3 + 0.25*4 + 3.0 = 1.0
        vecs[5] = '{w: {32'h0000_4000, 32'hFFFF_0000, 32'h0002_0000, 32'h0001_8000},
                    a: {32'h0004_0000, 32'h0003_0000, 32'hFFFE_8000, 32'h0002_0000},
                    b: 32'h0003_0000, exp_relu: 32'h0001_0000, exp_lin: 32'h0001_0000};

        for (int k = 0; k < 4; k++) begin
            wmem[k] = 32'h0;
            amem[k] = 32'h0;
        end

        #2;
        check("reset_result", res0, 32'h0);
        check("reset_valid", {31'b0, valid0}, 32'd0);
        check("reset_busy", {31'b0, busy0}, 32'd0);
        check("reset_addr", {30'b0, rom0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i].exp_relu, vecs[i].exp_lin);
        end

        // Output held under backpressure; start pulses while busy are ignored
        load_vec(0);
        pulse_start();
        wait_valid(1'b1, lat, lat2);
        check("hold_latency", 32'(lat), 32'd7);
        held = res0;
        check("hold_first", held, 32'h000A_8000);
        for (int h = 0; h < 5; h++) begin
            start = (h == 2);
            check("hold_valid", {31'b0, valid0}, 32'd1);
            check("hold_result", res0, 32'h000A_8000);
            @(posedge clk); #1;
        end
        start = 1'b0;
        handshake();
        for (int h = 0; h < 10; h++) begin
            check("no_rerun_busy", {31'b0, busy0}, 32'd0);
            check("no_rerun_valid", {31'b0, valid0}, 32'd0);
            check("idle_keeps_result", res0, 32'h000A_8000);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a run
        load_vec(0);
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("mid_rst_result", res0, 32'h0);
        check("mid_rst_result_lin", res1, 32'h0);
        check("mid_rst_valid", {31'b0, valid0}, 32'd0);
        check("mid_rst_busy", {31'b0, busy0}, 32'd0);
        check("mid_rst_addr", {30'b0, rom0}, 32'd0);
        @(posedge clk); #4;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", {31'b0, valid0}, 32'd0);
        run_vec(0, 32'h000A_8000, 32'h000A_8000);

        // Back-to-back: second start in the first IDLE cycle, with a new bias
        load_vec(0);
        pulse_start();
        wait_valid(1'b0, lat, lat2);
        check("b2b_first", res0, 32'h000A_8000);
        handshake();
        bias = 32'h0001_0000;
        pulse_start();
        wait_valid(1'b0, lat, lat2);
        check("b2b_latency", 32'(lat), 32'd7);
        check("b2b_result", res0, 32'h000B_0000);
        check("b2b_result_lin", res1, 32'h000B_0000);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
